// File: rtl/pwm_pkg.sv
// Shared types and defaults for the gen_pwm run sequencer.
package pwm_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned RUN_CNT_W_DEF = 16;
  localparam int unsigned TIMEOUT_DEF   = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } seq_state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_COUNT = 1'b1;

  // A sequence may launch only when enabled, re-armed, and count mode has a non-zero target.
  function automatic logic can_launch(input logic enable, input logic armed,
                                      input logic mode, input logic count_nz);
    return enable && armed && (mode == MODE_CONT || count_nz);
  endfunction

endpackage

// File: rtl/pwm_cfg_shadow.sv
// Shadow/active register pair for freq/duty; a write always beats a load strobe.
module pwm_cfg_shadow
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cfg_wr,
  input  logic [DATA_W-1:0] cfg_freq,
  input  logic [DATA_W-1:0] cfg_duty,
  input  logic              load,
  output logic [DATA_W-1:0] active_freq,
  output logic [DATA_W-1:0] active_duty,
  output logic              pending
);

  logic [DATA_W-1:0] shadow_freq;
  logic [DATA_W-1:0] shadow_duty;

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      shadow_freq <= '0;
      shadow_duty <= '0;
      active_freq <= '0;
      active_duty <= '0;
      pending     <= 1'b0;
    end else if (cfg_wr) begin
      shadow_freq <= cfg_freq;
      shadow_duty <= cfg_duty;
      pending     <= 1'b1;
    end else if (load && pending) begin
      active_freq <= shadow_freq;
      active_duty <= shadow_duty;
      pending     <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_run_sequencer.sv
// Drives the gen_pwm ap_ctrl_hs handshake: double-buffered config, N-run/continuous, watchdog, abort.
module pwm_run_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned RUN_CNT_W = RUN_CNT_W_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [DATA_W-1:0]    cfg_freq,
  input  logic [DATA_W-1:0]    cfg_duty,
  input  logic                 cfg_wr,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_mode,
  input  logic [RUN_CNT_W-1:0] ctrl_count,
  input  logic                 ctrl_abort,
  output logic                 ap_start,
  output logic                 ap_ce,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  input  logic                 ap_idle,
  input  logic                 out_r,
  input  logic                 out_r_ap_vld,
  output logic [DATA_W-1:0]    core_freq,
  output logic [DATA_W-1:0]    core_duty,
  output logic                 pwm_out,
  output logic                 busy,
  output logic                 cfg_pending,
  output logic [RUN_CNT_W-1:0] runs_done,
  output logic                 done_irq,
  output logic                 timeout_err
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  seq_state_t           state;
  logic                 armed;
  logic [WD_W-1:0]      wdog;
  logic [RUN_CNT_W-1:0] runs_inc;
  logic                 run_complete;
  logic                 last_run;
  logic                 launch;
  logic                 unused_ap_idle;

  assign unused_ap_idle = ap_idle;

  assign runs_inc     = runs_done + RUN_CNT_W'(1);
  assign run_complete = ((state == ST_START) && ap_ready && ap_done) ||
                        ((state == ST_WAIT) && ap_done);
  assign last_run     = (ctrl_mode == MODE_COUNT) && (runs_inc == ctrl_count);
  assign launch       = can_launch(ctrl_enable, armed, ctrl_mode, ctrl_count != '0);

  pwm_cfg_shadow #(
    .DATA_W (DATA_W)
  ) u_cfg_shadow (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cfg_wr      (cfg_wr),
    .cfg_freq    (cfg_freq),
    .cfg_duty    (cfg_duty),
    .load        (state == ST_LOAD),
    .active_freq (core_freq),
    .active_duty (core_duty),
    .pending     (cfg_pending)
  );

  // Sequencer FSM; abort first, then run completion, then per-state moves.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state       <= ST_IDLE;
      ap_start    <= 1'b0;
      ap_ce       <= 1'b1;
      busy        <= 1'b0;
      runs_done   <= '0;
      done_irq    <= 1'b0;
      timeout_err <= 1'b0;
      pwm_out     <= 1'b0;
      armed       <= 1'b1;
      wdog        <= '0;
    end else begin
      done_irq <= 1'b0;
      if (!ctrl_enable) armed <= 1'b1;
      if (out_r_ap_vld && (state != ST_ERR)) pwm_out <= out_r;

      if (ctrl_abort) begin
        state       <= ST_IDLE;
        ap_start    <= 1'b0;
        ap_ce       <= 1'b1;
        timeout_err <= 1'b0;
        busy        <= 1'b0;
        pwm_out     <= 1'b0;
      end else if (run_complete) begin
        runs_done <= runs_inc;
        ap_start  <= 1'b0;
        if (last_run) begin
          state    <= ST_DONE;
          done_irq <= 1'b1;
        end else if (!ctrl_enable) begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          pwm_out <= 1'b0;
        end else begin
          state <= ST_LOAD;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (launch) begin
              state     <= ST_LOAD;
              busy      <= 1'b1;
              runs_done <= '0;
            end
          end
          ST_LOAD: begin
            wdog     <= '0;
            state    <= ST_START;
            ap_start <= 1'b1;
          end
          ST_START: begin
            if (ap_ready) begin
              state    <= ST_WAIT;
              ap_start <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (wdog == WD_W'(TIMEOUT - 1)) begin
              state       <= ST_ERR;
              timeout_err <= 1'b1;
              ap_ce       <= 1'b0;
              pwm_out     <= 1'b0;
            end else begin
              wdog <= wdog + WD_W'(1);
            end
          end
          ST_DONE: begin
            armed   <= 1'b0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
            pwm_out <= 1'b0;
          end
          ST_ERR: begin
            state <= ST_ERR;
          end
          default: begin
            state    <= ST_IDLE;
            ap_start <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_run_sequencer.md
Name: pwm_run_sequencer

Overview:
- Controller that sequences the HLS gen_pwm core through its ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_ce).
- Double-buffers freq/duty so the core's inputs change only between runs.
- Supports continuous or N-run operation, a watchdog timeout, and abort.
- Sits between the AHB register wrapper (config/control side) and the gen_pwm instance (core side).

Parameters:
DATA_W, 32, width of freq/duty values
RUN_CNT_W, 16, width of run target and run counter
TIMEOUT, 16'hFFFF, max cycles in WAIT before error (TIMEOUT >= 2)

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  asynchronous reset, active-HIGH (name kept per codebase; asserted = 1)
cfg_freq  in  DATA_W  new frequency value
cfg_duty  in  DATA_W  new duty value
cfg_wr  in  1  pulse: capture cfg_freq/cfg_duty into shadow
ctrl_enable  in  1  level: run while high
ctrl_mode  in  1  0 = continuous, 1 = count mode
ctrl_count  in  RUN_CNT_W  target runs in count mode
ctrl_abort  in  1  pulse: return to IDLE from any state
ap_start  out  1  core start
ap_ce  out  1  core clock enable
ap_ready  in  1  core accepted start
ap_done  in  1  core run complete
ap_idle  in  1  core idle (status only)
out_r  in  1  core PWM sample
out_r_ap_vld  in  1  out_r valid
core_freq  out  DATA_W  active freq to core
core_duty  out  DATA_W  active duty to core
pwm_out  out  1  registered PWM output
busy  out  1  state != IDLE
cfg_pending  out  1  shadow not yet applied
runs_done  out  RUN_CNT_W  completed runs this sequence
done_irq  out  1  1-cycle pulse at count-mode completion
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE; all outputs 0 except ap_ce = 1; shadow/active regs 0; armed = 1.
- Shadow: cfg_wr loads shadow and sets cfg_pending. cfg_wr coinciding with LOAD: the new value goes to shadow, cfg_pending stays 1, active is not updated this cycle.
- States (the only clocked FSM):
  - IDLE: ap_start = 0. If ctrl_enable && armed && (ctrl_mode == 0 || ctrl_count != 0), go to LOAD and clear runs_done. armed is set whenever ctrl_enable = 0.
  - LOAD (1 cycle): if cfg_pending and no cfg_wr, active <= shadow and cfg_pending <= 0. Clear watchdog. Go to START.
  - START: ap_start = 1, held until ap_ready = 1. On ap_ready with ap_done the same cycle, do completion (below). On ap_ready alone, go to WAIT.
  - WAIT: ap_start = 0; watchdog increments. On ap_done, do completion. If the watchdog reaches TIMEOUT-1 with no ap_done, go to ERR; ap_done in that same cycle wins.
  - Completion: runs_done++ (wraps in continuous mode).
    - Count mode with runs_done+1 == ctrl_count: go to DONE.
    - Otherwise, ctrl_enable = 0: go to IDLE.
    - Otherwise: go to LOAD.
  - DONE (1 cycle): done_irq = 1, armed <= 0, go to IDLE.
  - ERR: timeout_err <= 1, ap_ce = 0, ap_start = 0. Exit only via ctrl_abort.
- Latency: ctrl_enable rising in IDLE at cycle n gives LOAD at n+1 and ap_start = 1 at n+2.
- ctrl_abort: any state goes to IDLE next cycle. ap_start drops and timeout_err clears; runs_done and shadow are kept. Abort beats every other transition.
- pwm_out <= out_r when out_r_ap_vld. Cleared to 0 on entry to IDLE or ERR.
- Reset asserted mid-run: immediate return to reset values; a pending cfg_wr is lost.

Decomposition:
- Shared package pwm_pkg: state encoding constants (IDLE, LOAD, START, WAIT, DONE, ERR), mode encodings, DATA_W default.
- One natural sub-module: pwm_cfg_shadow (shadow/active register pair plus pending flag, with load-strobe priority rules). Watchdog stays inline.

Test Plan:
- Reset, then cfg_wr freq = 1000, duty = 250, mode 0, enable -> ap_start at cycle +2; core_freq = 1000 and core_duty = 250 once LOAD completes; cfg_pending 1 -> 0.
- Count mode, ctrl_count = 3, core model done 5 cycles after ready -> exactly 3 ap_start assertions, runs_done = 3, single done_irq pulse, no restart until enable toggles low then high.
- cfg_wr duty = 500 during WAIT -> core_duty stays 250 until the next LOAD, then 500. A cfg_wr in the LOAD cycle is deferred one run.
- ap_ready and ap_done asserted the same cycle as ap_start -> no WAIT cycle; runs_done increments and LOAD follows next cycle.
- TIMEOUT = 8, core never asserts done -> ERR after 8 WAIT cycles; timeout_err = 1, ap_ce = 0, pwm_out = 0. ctrl_abort -> IDLE, timeout_err = 0, ap_ce = 1.
- ctrl_abort in START while ap_start = 1 -> ap_start = 0 next cycle, busy = 0. Async reset mid-WAIT -> all outputs at reset values without a clock edge.
